mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data (MEM-stage) port of the 5-stage MIPS pipeline.
- Accepts one request at a time and runs the address and data phases on the bus. Returns handshakes and read data to the winning port.
- Drives `mem_busy`, which the hazard logic turns into Stall_*/Flush_* controls.
- Sits between the pipeline datapath/controller and the cache/AXI bridge.

Parameters:
- ADDR_W, 32, address width of both ports and the bus.
- DATA_W, 32, data width; DATA_W/8 is the strobe width.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held with its fields stable until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted by the bus
- inst_data_ok  out  1  fetch data valid on inst_rdata
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  load/store request; held with its fields stable until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  DATA_W/8  byte strobes (the 4-bit MemWrite_M)
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted by the bus
- data_data_ok  out  1  load data valid, or store completed
- data_rdata  out  DATA_W  load data
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus transfer size
- bus_wstrb  out  DATA_W/8  bus byte strobes
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok  in  1  bus accepted the address phase
- bus_data_ok  in  1  bus data phase complete
- bus_rdata  in  DATA_W  bus read data
- mem_busy  out  1  a request is pending or in flight

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. A 1-bit `last_grant` register records the last winner (0 = inst, 1 = data).
- Reset (rst=1 at a clock edge): state returns to IDLE and last_grant to 0, including mid-transaction. Any bus response still owed is discarded. All outputs are 0 while in IDLE after reset.
- In IDLE, with only data_req set: latch the wr, size, wstrb, addr and wdata fields into request registers and go to D_ADDR.
- In IDLE, with only inst_req set: latch addr, force wr=0, size=2, wstrb=0, and go to I_ADDR.
- In IDLE, with both requests set: data wins, unless last_grant=1, in which case inst wins (round-robin anti-starvation). last_grant is updated on every grant.
- X_ADDR states:
  - bus_req=1 and the bus_* fields come from the request registers, so they are stable for the whole address phase.
  - When bus_addr_ok=1: pulse the matching *_addr_ok for exactly that cycle, then go to X_DATA.
  - bus_req may stay high for any number of cycles; there is no timeout.
- X_DATA states:
  - bus_req=0.
  - When bus_data_ok=1: the matching *_data_ok is driven combinationally in the same cycle, with *_rdata = bus_rdata. Then go to IDLE.
- *_rdata is 0 whenever the matching *_data_ok=0.
- Spurious responses are ignored: bus_addr_ok outside X_ADDR, and bus_data_ok outside X_DATA (including in the same cycle as addr_ok).
- Latency:
  - Request to bus_req takes 1 cycle (registered grant).
  - The best-case single transaction is 3 cycles: request, addr_ok, data_ok.
  - The next grant happens in the cycle after data_ok. There is no back-to-back issue; only one transaction is outstanding at a time.
- mem_busy = (state != IDLE) | inst_req | data_req.
- A request dropped before acceptance is not supported. The requester must hold its request until *_addr_ok.
- An unmasked write (data_wr=1 with data_wstrb=0) is forwarded unchanged. The except_type_M masking happens upstream.
- No outputs are registered other than state, last_grant and the request registers.

Decomposition:
- Shared package `mem_pkg`:
  - state encoding constants ARB_IDLE, ARB_I_ADDR, ARB_I_DATA, ARB_D_ADDR, ARB_D_DATA;
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- Optional sub-module `arb_req_latch`: a parameterised enable register holding one port's request fields, instantiated twice.
- Everything else stays inline.

Test Plan:
- Fetch only. inst_req=1, addr=0xBFC00000; bus_addr_ok at cycle 2, bus_data_ok at cycle 4 with rdata=0x24080001. Required: bus_req high in cycles 1-2 with bus_addr=0xBFC00000 and bus_wr=0; inst_addr_ok pulses in cycle 2; inst_data_ok=1 with rdata=0x24080001 in cycle 4; IDLE in cycle 5.
- Store. data_req=1, wr=1, size=2, wstrb=0xF, addr=0x80000010, wdata=0xDEADBEEF. Required: the bus fields match exactly; data_data_ok is asserted on bus_data_ok; inst_* stay 0 throughout.
- Simultaneous requests from reset. Required: data is granted first. Both requests are held, and after the data completes, inst is granted next even though data_req is still 1.
- Bus wait states. bus_addr_ok held low for 5 cycles. Required: bus_req and all bus fields stay constant; no *_addr_ok pulse occurs until bus_addr_ok=1.
- Spurious handshakes. bus_data_ok=1 while in IDLE or I_ADDR. Required: no *_data_ok output and no state change.
- Reset mid-operation. rst=1 while in D_DATA. Required: IDLE on the next edge, all outputs 0, last_grant=0, and a late bus_data_ok produces no data_data_ok.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
package mem_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_ADDR = 3'd1,
    ARB_I_DATA = 3'd2,
    ARB_D_ADDR = 3'd3,
    ARB_D_DATA = 3'd4
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_req_latch.sv
// Enable register capturing one port's request fields at grant time.
module arb_req_latch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] fields_q;
  logic [W-1:0] fields_d;

  always_comb begin
    fields_d = en ? d : fields_q;
  end

  // Data-only storage: contents are meaningless until the first grant.
  always_ff @(posedge clk) begin
    fields_q <= fields_d;
  end

  assign q = fields_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM-like bus between the fetch and load/store ports.
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                mem_busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DREQ_W = 1 + 2 + STRB_W + ADDR_W + DATA_W;

  arb_state_t          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_inst, grant_data;
  logic [ADDR_W-1:0]   inst_fields_q;
  logic [DREQ_W-1:0]   data_fields_q;
  logic                dreq_wr;
  logic [1:0]          dreq_size;
  logic [STRB_W-1:0]   dreq_wstrb;
  logic [ADDR_W-1:0]   dreq_addr;
  logic [DATA_W-1:0]   dreq_wdata;

  arb_req_latch #(.W(ADDR_W)) u_inst_latch (
    .clk (clk),
    .en  (grant_inst),
    .d   (inst_addr),
    .q   (inst_fields_q)
  );

  arb_req_latch #(.W(DREQ_W)) u_data_latch (
    .clk (clk),
    .en  (grant_data),
    .d   ({data_wr, data_size, data_wstrb, data_addr, data_wdata}),
    .q   (data_fields_q)
  );

  assign {dreq_wr, dreq_size, dreq_wstrb, dreq_addr, dreq_wdata} = data_fields_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_wstrb    = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    unique case (state_q)
      ARB_IDLE: begin
        // Data wins a tie unless it also won the previous grant.
        if (data_req && (!inst_req || !last_grant_q)) begin
          grant_data   = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ARB_D_ADDR;
        end else if (inst_req) begin
          grant_inst   = 1'b1;
          last_grant_d = 1'b0;
          state_d      = ARB_I_ADDR;
        end
      end
      ARB_I_ADDR: begin
        bus_req  = 1'b1;
        bus_size = SZ_WORD;
        bus_addr = inst_fields_q;
        if (bus_addr_ok) begin
          inst_addr_ok = 1'b1;
          state_d      = ARB_I_DATA;
        end
      end
      ARB_I_DATA: begin
        if (bus_data_ok) begin
          inst_data_ok = 1'b1;
          inst_rdata   = bus_rdata;
          state_d      = ARB_IDLE;
        end
      end
      ARB_D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = dreq_wr;
        bus_size  = dreq_size;
        bus_wstrb = dreq_wstrb;
        bus_addr  = dreq_addr;
        bus_wdata = dreq_wdata;
        if (bus_addr_ok) begin
          data_addr_ok = 1'b1;
          state_d      = ARB_D_DATA;
        end
      end
      ARB_D_DATA: begin
        if (bus_data_ok) begin
          data_data_ok = 1'b1;
          data_rdata   = bus_rdata;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_busy = (state_q != ARB_IDLE) | inst_req | data_req;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: random request batches, random-latency bus slave, round-robin reference model.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          is_data;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        mem_busy;

  bus_exp_t    exp_bus_q[$];
  resp_exp_t   exp_resp_q[$];
  logic [31:0] rdata_q[$];
  logic [31:0] inst_cmd_q[$];
  bus_exp_t    data_cmd_q[$];
  logic [31:0] st_i[$];
  bus_exp_t    st_d[$];
  logic [31:0] st_rd[$];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  bit hold_data = 1'b0;
  bit spur_en = 1'b1;
  bit last_data = 1'b0;
  bit aborted = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .mem_busy     (mem_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch requester: holds each request until its addr_ok is seen.
  initial begin : inst_drv
    int n;
    inst_req  = 1'b0;
    inst_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (inst_cmd_q.size() > 0) begin
        inst_req  = 1'b1;
        inst_addr = inst_cmd_q.pop_front();
        n = 0;
        do begin @(negedge clk); n++; end while (!inst_addr_ok && n < 1000);
      end else begin
        inst_req  = 1'b0;
        inst_addr = $urandom;
      end
    end
  end

  initial begin : data_drv
    int n;
    bus_exp_t c;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (data_cmd_q.size() > 0) begin
        c = data_cmd_q.pop_front();
        data_req = 1'b1; data_wr = c.wr; data_size = c.size; data_wstrb = c.wstrb;
        data_addr = c.addr; data_wdata = c.wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!data_addr_ok && n < 1000);
      end else begin
        data_req = 1'b0; data_wr = 1'($urandom); data_size = 2'($urandom);
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
    end
  end

  // Bus slave: random address/data wait states plus spurious handshakes outside their phase.
  initial begin : responder
    int phase;
    int wcnt;
    phase = 0;
    wcnt = 0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (phase == 0) begin
        if (bus_req) begin
          if (spur_en) bus_data_ok = ($urandom_range(0, 2) == 0);
          if (wcnt == 0) begin
            bus_addr_ok = 1'b1;
            phase = 1;
            wcnt = $urandom_range(0, 4);
          end else wcnt--;
        end else if (spur_en) begin
          bus_addr_ok = ($urandom_range(0, 3) == 0);
          bus_data_ok = ($urandom_range(0, 3) == 0);
        end
      end else begin
        if (spur_en) bus_addr_ok = ($urandom_range(0, 3) == 0);
        if (!hold_data) begin
          if (wcnt == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
            phase = 0;
            wcnt = $urandom_range(0, 5);
          end else wcnt--;
        end
      end
    end
  end

  initial begin : monitor
    bus_exp_t  h;
    resp_exp_t r;
    bit        hv;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      hv = (exp_bus_q.size() > 0);
      if (hv) h = exp_bus_q[0];
      if (bus_req) begin
        chk("bus_req_expected", 32'(hv), 32'd1);
        if (hv) begin
          chk("bus_wr", 32'(bus_wr), 32'(h.wr));
          chk("bus_size", 32'(bus_size), 32'(h.size));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(h.wstrb));
          chk("bus_addr", bus_addr, h.addr);
          if (h.is_data) chk("bus_wdata", bus_wdata, h.wdata);
          chk("inst_addr_ok", 32'(inst_addr_ok), 32'(bus_addr_ok && !h.is_data));
          chk("data_addr_ok", 32'(data_addr_ok), 32'(bus_addr_ok && h.is_data));
          if (bus_addr_ok) void'(exp_bus_q.pop_front());
        end
      end else begin
        chk("inst_addr_ok_nobus", 32'(inst_addr_ok), 32'd0);
        chk("data_addr_ok_nobus", 32'(data_addr_ok), 32'd0);
      end
      if (inst_data_ok || data_data_ok) begin
        chk("data_ok_expected", 32'(exp_resp_q.size() > 0), 32'd1);
        if (exp_resp_q.size() > 0) begin
          r = exp_resp_q.pop_front();
          chk("inst_data_ok", 32'(inst_data_ok), 32'(!r.is_data));
          chk("data_data_ok", 32'(data_data_ok), 32'(r.is_data));
          if (r.is_data) chk("data_rdata", data_rdata, r.rdata);
          else           chk("inst_rdata", inst_rdata, r.rdata);
        end
      end
      if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 32'd0);
      if (!data_data_ok) chk("data_rdata_zero", data_rdata, 32'd0);
      if (inst_req || data_req || bus_req) chk("mem_busy_set", 32'(mem_busy), 32'd1);
    end
  end

  // Reference model: serve queued requests one at a time, alternating on contention.
  task automatic run_batch();
    int ii, di, n;
    bit pick_d;
    bus_exp_t e;
    resp_exp_t r;
    logic [31:0] rd;
    ii = 0; di = 0;
    while (ii < st_i.size() || di < st_d.size()) begin
      pick_d = (di < st_d.size()) && (ii >= st_i.size() || !last_data);
      if (pick_d) begin
        e = st_d[di]; e.is_data = 1'b1; di++;
      end else begin
        e.is_data = 1'b0; e.wr = 1'b0; e.size = 2'd2; e.wstrb = 4'h0;
        e.addr = st_i[ii]; e.wdata = '0; ii++;
      end
      rd = (st_rd.size() > 0) ? st_rd.pop_front() : $urandom;
      exp_bus_q.push_back(e);
      r.is_data = pick_d; r.rdata = rd;
      exp_resp_q.push_back(r);
      rdata_q.push_back(rd);
      last_data = pick_d;
    end
    foreach (st_i[k]) inst_cmd_q.push_back(st_i[k]);
    foreach (st_d[k]) data_cmd_q.push_back(st_d[k]);
    st_i.delete(); st_d.delete(); st_rd.delete();
    n = 0;
    while (exp_resp_q.size() > 0 && n < 400) begin @(negedge clk); n++; end
    chk("batch_complete", 32'(exp_resp_q.size()), 32'd0);
    if (exp_resp_q.size() > 0) aborted = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("idle_mem_busy", 32'(mem_busy), 32'd0);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
  endtask

  function automatic bus_exp_t rand_dcmd();
    bus_exp_t c;
    c.is_data = 1'b1; c.wr = 1'($urandom); c.size = 2'($urandom_range(0, 2));
    c.wstrb = 4'($urandom); c.addr = $urandom; c.wdata = $urandom;
    return c;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_bus_size"}, 32'(bus_size), 32'd0);
    chk({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
    chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'd0);
    chk({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
    chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'd0);
    chk({tag, "_data_rdata"}, data_rdata, 32'd0);
    chk({tag, "_mem_busy"}, 32'(mem_busy), 32'd0);
  endtask

  initial begin : stimulus
    bus_exp_t c;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    st_i.push_back(32'hBFC0_0000);
    st_rd.push_back(32'h2408_0001);
    run_batch();

    c.is_data = 1'b1; c.wr = 1'b1; c.size = 2'd2; c.wstrb = 4'hF;
    c.addr = 32'h8000_0010; c.wdata = 32'hDEAD_BEEF;
    st_d.push_back(c);
    run_batch();

    for (int b = 0; b < 40 && !aborted; b++) begin
      int ni, nd;
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (ni == 0 && nd == 0) ni = 1;
      for (int k = 0; k < ni; k++) st_i.push_back($urandom);
      for (int k = 0; k < nd; k++) st_d.push_back(rand_dcmd());
      run_batch();
    end

    if (!aborted) begin
      // Reset while the data transaction waits in its data phase.
      hold_data = 1'b1;
      c = rand_dcmd();
      exp_bus_q.push_back(c);
      rdata_q.push_back(32'h0BAD_0BAD);
      data_cmd_q.push_back(c);
      n = 0;
      do begin @(negedge clk); n++; end while (!data_addr_ok && n < 100);
      chk("rst_test_addr_ok", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      chk("rst_test_in_data_phase", 32'(bus_req), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      hold_data = 1'b0;
      last_data = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("late_data_ok_dropped", 32'(data_data_ok), 32'd0);
      end

      // Contention from reset: data, then inst despite data_req re-asserted, then data.
      st_d.push_back(rand_dcmd());
      st_d.push_back(rand_dcmd());
      st_i.push_back($urandom);
      run_batch();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
